// File: rtl/imem_boot_loader_pkg.sv
// Shared types for the UART instruction-memory boot loader.
// State encodings are visible on the debug port, so their values are fixed.
package imem_boot_loader_pkg;

  typedef enum logic [2:0] {
    ST_SYNC   = 3'd0,
    ST_LEN_HI = 3'd1,
    ST_LEN_LO = 3'd2,
    ST_DATA   = 3'd3,
    ST_CSUM   = 3'd4,
    ST_DONE   = 3'd5,
    ST_ERR    = 3'd6
  } boot_state_t;

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP
  } rx_state_t;

  localparam logic [7:0] DEFAULT_SYNC_BYTE = 8'hA5;

endpackage

// File: rtl/uart_byte_rx.sv
// 8N1 UART byte receiver: synchronizes the pin, finds the start bit and
// samples each bit near its centre. A low stop bit drops the byte.
module uart_byte_rx
  import imem_boot_loader_pkg::*;
#(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       uart_rxd,
  output logic [7:0] rx_byte,
  output logic       rx_valid,
  output logic       frame_err
);

  localparam int CW = $clog2(CLKS_PER_BIT + 1);
  localparam logic [CW-1:0] BIT_END = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF    = CW'(CLKS_PER_BIT / 2 - 1);

  logic [2:0]    sync;
  rx_state_t     st, st_d;
  logic [CW-1:0] cnt, cnt_d;
  logic [2:0]    bit_idx, bit_d;
  logic [7:0]    shreg, sh_d;
  logic          rxd_s, fall;

  assign rxd_s   = sync[1];
  assign fall    = sync[2] & ~sync[1];
  assign rx_byte = shreg;

  always_comb begin
    st_d      = st;
    cnt_d     = cnt + CW'(1);
    bit_d     = bit_idx;
    sh_d      = shreg;
    rx_valid  = 1'b0;
    frame_err = 1'b0;
    unique case (st)
      RX_IDLE: begin
        cnt_d = '0;
        if (fall) st_d = RX_START;
      end
      // a start bit that is high again at mid-bit was a glitch
      RX_START: if (cnt == HALF) begin
        cnt_d = '0;
        st_d  = rxd_s ? RX_IDLE : RX_DATA;
      end
      RX_DATA: if (cnt == BIT_END) begin
        cnt_d = '0;
        sh_d  = {rxd_s, shreg[7:1]};
        bit_d = bit_idx + 3'd1;
        if (bit_idx == 3'd7) st_d = RX_STOP;
      end
      RX_STOP: if (cnt == BIT_END) begin
        st_d      = RX_IDLE;
        rx_valid  = rxd_s;
        frame_err = ~rxd_s;
      end
      default: st_d = RX_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync    <= '1;
      st      <= RX_IDLE;
      cnt     <= '0;
      bit_idx <= '0;
      shreg   <= '0;
    end else begin
      sync    <= {sync[1:0], uart_rxd};
      st      <= st_d;
      cnt     <= cnt_d;
      bit_idx <= bit_d;
      shreg   <= sh_d;
    end
  end

endmodule

// File: rtl/imem_boot_loader.sv
// Receives a framed program image over UART, writes it into instruction
// memory and releases cpu_reset only after a complete, checksummed frame.
module imem_boot_loader
  import imem_boot_loader_pkg::*;
#(
  parameter int         CLKS_PER_BIT = 434,
  parameter int         ADDR_W       = 8,
  parameter logic [7:0] SYNC_BYTE    = DEFAULT_SYNC_BYTE,
  parameter int         TIMEOUT_CYC  = 2000000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              uart_rxd,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              cpu_reset,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [15:0]       words_loaded,
  output logic [2:0]        state
);

  localparam int IW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [16:0] CAPACITY = 17'(1) << ADDR_W;

  logic [7:0] rx_byte;
  logic       rx_valid, frame_err;

  uart_byte_rx #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
    .clk       (clk),
    .reset     (reset),
    .uart_rxd  (uart_rxd),
    .rx_byte   (rx_byte),
    .rx_valid  (rx_valid),
    .frame_err (frame_err)
  );

  boot_state_t       state_q, st_d;
  logic [15:0]       len_q, len_d, word_idx_q, widx_d, wl_d, n_words;
  logic [1:0]        byte_idx_q, bidx_d;
  logic [31:0]       word_q, word_d, wdata_d, word_full;
  logic [7:0]        csum_q, csum_d;
  logic [IW-1:0]     idle_q, idle_d;
  logic [ADDR_W-1:0] addr_d;
  logic              we_d, cpu_reset_d, done_d, error_d;

  assign state = state_q;
  assign busy  = state_q inside {ST_LEN_HI, ST_LEN_LO, ST_DATA, ST_CSUM};

  always_comb begin
    st_d        = state_q;
    len_d       = len_q;
    widx_d      = word_idx_q;
    bidx_d      = byte_idx_q;
    word_d      = word_q;
    csum_d      = csum_q;
    idle_d      = '0;
    wl_d        = words_loaded;
    we_d        = 1'b0;
    addr_d      = imem_addr;
    wdata_d     = imem_wdata;
    cpu_reset_d = cpu_reset;
    done_d      = done;
    error_d     = error;
    n_words     = {len_q[15:8], rx_byte};
    word_full   = {word_q[23:0], rx_byte};
    unique case (state_q)
      ST_SYNC, ST_DONE, ST_ERR: begin
        if (state_q == ST_DONE) cpu_reset_d = 1'b0;
        if (rx_valid && rx_byte == SYNC_BYTE) begin
          st_d        = ST_LEN_HI;
          cpu_reset_d = 1'b1;
          done_d      = 1'b0;
          error_d     = 1'b0;
          wl_d        = '0;
        end
      end
      ST_LEN_HI: if (rx_valid) begin
        len_d[15:8] = rx_byte;
        csum_d      = rx_byte;
        st_d        = ST_LEN_LO;
      end
      ST_LEN_LO: if (rx_valid) begin
        len_d[7:0] = rx_byte;
        csum_d     = csum_q ^ rx_byte;
        widx_d     = '0;
        bidx_d     = '0;
        if ({1'b0, n_words} > CAPACITY) st_d = ST_ERR;
        else if (n_words == 16'd0)      st_d = ST_CSUM;
        else                            st_d = ST_DATA;
      end
      ST_DATA: if (rx_valid) begin
        csum_d = csum_q ^ rx_byte;
        word_d = word_full;
        bidx_d = byte_idx_q + 2'd1;
        if (byte_idx_q == 2'd3) begin
          we_d    = 1'b1;
          addr_d  = word_idx_q[ADDR_W-1:0];
          wdata_d = word_full;
          wl_d    = word_idx_q + 16'd1;
          widx_d  = word_idx_q + 16'd1;
          if (word_idx_q == len_q - 16'd1) st_d = ST_CSUM;
        end
      end
      ST_CSUM: if (rx_valid) st_d = (rx_byte == csum_q) ? ST_DONE : ST_ERR;
      default: st_d = ST_SYNC;
    endcase
    // a stalled or corrupted link aborts the frame in progress
    if (busy) begin
      if (frame_err) st_d = ST_ERR;
      else if (!rx_valid) begin
        if (idle_q == IW'(TIMEOUT_CYC - 1)) st_d = ST_ERR;
        else idle_d = idle_q + IW'(1);
      end
    end
    if (st_d == ST_DONE && state_q != ST_DONE) begin
      done_d  = 1'b1;
      error_d = 1'b0;
    end
    if (st_d == ST_ERR && state_q != ST_ERR) begin
      error_d     = 1'b1;
      done_d      = 1'b0;
      cpu_reset_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_SYNC;
      len_q        <= '0;
      word_idx_q   <= '0;
      byte_idx_q   <= '0;
      word_q       <= '0;
      csum_q       <= '0;
      idle_q       <= '0;
      words_loaded <= '0;
      imem_we      <= 1'b0;
      imem_addr    <= '0;
      imem_wdata   <= '0;
      cpu_reset    <= 1'b1;
      done         <= 1'b0;
      error        <= 1'b0;
    end else begin
      state_q      <= st_d;
      len_q        <= len_d;
      word_idx_q   <= widx_d;
      byte_idx_q   <= bidx_d;
      word_q       <= word_d;
      csum_q       <= csum_d;
      idle_q       <= idle_d;
      words_loaded <= wl_d;
      imem_we      <= we_d;
      imem_addr    <= addr_d;
      imem_wdata   <= wdata_d;
      cpu_reset    <= cpu_reset_d;
      done         <= done_d;
      error        <= error_d;
    end
  end

endmodule

// File: tb/tb_imem_boot_loader.sv
// Bench for imem_boot_loader: table-driven frames, directed corner cases and
// random frames checked against a frame-level model of expected writes.
module tb_imem_boot_loader;

  localparam int CPB = 4;
  localparam int TMO = 200;

  logic clk = 1'b0, reset = 1'b1, rxd = 1'b1;
  always #5 clk = ~clk;

  logic        imem_we, cpu_reset, busy, done, error;
  logic [7:0]  imem_addr;
  logic [31:0] imem_wdata;
  logic [15:0] words_loaded;
  logic [2:0]  state;

  logic        imem_we4, cpu_reset4, busy4, done4, error4;
  logic [3:0]  imem_addr4;
  logic [31:0] imem_wdata4;
  logic [15:0] words_loaded4;
  logic [2:0]  state4;

  imem_boot_loader #(.CLKS_PER_BIT(CPB), .ADDR_W(8), .SYNC_BYTE(8'hA5), .TIMEOUT_CYC(TMO)) dut (
    .clk(clk), .reset(reset), .uart_rxd(rxd), .imem_we(imem_we), .imem_addr(imem_addr),
    .imem_wdata(imem_wdata), .cpu_reset(cpu_reset), .busy(busy), .done(done), .error(error),
    .words_loaded(words_loaded), .state(state));

  imem_boot_loader #(.CLKS_PER_BIT(CPB), .ADDR_W(4), .SYNC_BYTE(8'hA5), .TIMEOUT_CYC(TMO)) dut4 (
    .clk(clk), .reset(reset), .uart_rxd(rxd), .imem_we(imem_we4), .imem_addr(imem_addr4),
    .imem_wdata(imem_wdata4), .cpu_reset(cpu_reset4), .busy(busy4), .done(done4), .error(error4),
    .words_loaded(words_loaded4), .state(state4));

  int n_cmp = 0, n_fail = 0;

  // observed writes of the 8-bit-address DUT as {addr, data}
  logic [39:0] wq[$];
  int we4_cnt = 0;
  always @(negedge clk) begin
    if (imem_we) wq.push_back({imem_addr, imem_wdata});
    if (imem_we4) we4_cnt = we4_cnt + 1;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop);
    rxd = 1'b0; repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rxd = b[i]; repeat (CPB) @(negedge clk);
    end
    rxd = stop; repeat (CPB) @(negedge clk);
    rxd = 1'b1; repeat (3) @(negedge clk);
  endtask

  logic [7:0]  fb[$];   // bytes to transmit
  logic [31:0] ew[$];   // expected words written at addresses 0..N-1

  task automatic send_frame();
    foreach (fb[i]) send_byte(fb[i], 1'b1);
  endtask

  // model: frame is sync, big-endian length, words MSB first, xor checksum
  task automatic build_frame(input int n, input bit bad);
    logic [15:0] len;
    logic [7:0]  cs;
    len = 16'(n);
    cs  = len[15:8] ^ len[7:0];
    fb  = {};
    fb.push_back(8'hA5);
    fb.push_back(len[15:8]);
    fb.push_back(len[7:0]);
    for (int w = 0; w < n; w++)
      for (int b = 3; b >= 0; b--) begin
        fb.push_back(ew[w][8*b +: 8]);
        cs = cs ^ ew[w][8*b +: 8];
      end
    fb.push_back(bad ? (cs ^ 8'h07) : cs);
  endtask

  task automatic check_writes(input int base, input string name);
    chk({name, " write count"}, 64'(wq.size() - base), 64'(ew.size()));
    for (int i = 0; i < ew.size(); i++)
      if (base + i < wq.size()) chk({name, " write"}, 64'(wq[base + i]), {24'h0, 8'(i), ew[i]});
  endtask

  task automatic wait_st(input logic [2:0] s, input string name);
    int k = 0;
    while (state !== s && k < 2000) begin
      @(negedge clk);
      k++;
    end
    chk(name, 64'(state), 64'(s));
  endtask

  task automatic chk_reset(input string name);
    chk({name, " dut"}, 64'({imem_we, imem_addr, imem_wdata, cpu_reset, busy, done, error, words_loaded, state}),
        64'({1'b0, 8'h0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0, 3'd0}));
    chk({name, " dut4"}, 64'({imem_we4, imem_addr4, imem_wdata4, cpu_reset4, busy4, done4, error4, words_loaded4, state4}),
        64'({1'b0, 4'h0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0, 3'd0}));
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
  endtask

  typedef struct {
    int          n;
    logic [31:0] w[4];
    bit          bad;
    bit          exp_done;
    bit          exp_err;
    logic [15:0] exp_wl;
  } vec_t;

  vec_t tbl[4];

  initial begin
    int base, base4, n, ng;
    bit bad;
    logic [7:0] g;

    tbl[0] = '{1, '{32'hDEADBEEF, 32'h0, 32'h0, 32'h0}, 1'b0, 1'b1, 1'b0, 16'd1};
    tbl[1] = '{4, '{32'h00000013, 32'hFFFFFFFF, 32'h12345678, 32'hA5A5A5A5}, 1'b0, 1'b1, 1'b0, 16'd4};
    tbl[2] = '{3, '{32'hCAFEF00D, 32'h00A50000, 32'h80000001, 32'h0}, 1'b1, 1'b0, 1'b1, 16'd3};
    tbl[3] = '{0, '{32'h0, 32'h0, 32'h0, 32'h0}, 1'b0, 1'b1, 1'b0, 16'd0};

    repeat (3) @(negedge clk);
    chk_reset("reset values");
    reset = 1'b0;
    @(negedge clk);

    // 1: good two-word frame, cpu_reset falls one cycle after DONE
    ew = {32'h20080005, 32'h0000000C};
    build_frame(2, 1'b0);
    chk("t1 frame bytes csum", 64'(fb[11]), 64'h23);
    base = wq.size();
    fork
      send_frame();
      begin
        wait_st(3'd5, "t1 enter DONE");
        chk("t1 cpu_reset at DONE entry", 64'(cpu_reset), 64'd1);
        @(negedge clk);
        chk("t1 cpu_reset after DONE", 64'(cpu_reset), 64'd0);
      end
    join
    repeat (5) @(negedge clk);
    chk("t1 done/error/wl", 64'({done, error, words_loaded}), 64'({1'b1, 1'b0, 16'd2}));
    check_writes(base, "t1");

    // 2: bad checksum writes but errors; resend recovers
    build_frame(2, 1'b1);
    base = wq.size();
    send_frame();
    repeat (5) @(negedge clk);
    chk("t2 bad csum state", 64'({done, error, cpu_reset, state}), 64'({1'b0, 1'b1, 1'b1, 3'd6}));
    check_writes(base, "t2");
    build_frame(2, 1'b0);
    send_frame();
    repeat (5) @(negedge clk);
    chk("t2 resend", 64'({done, error, cpu_reset}), 64'({1'b1, 1'b0, 1'b0}));

    // 3: garbage while hunting for sync
    pulse_reset();
    base = wq.size();
    send_byte(8'h00, 1'b1);
    send_byte(8'hFF, 1'b1);
    send_byte(8'h3C, 1'b1);
    chk("t3 garbage ignored", 64'({state, busy}), 64'({3'd0, 1'b0}));
    send_frame();
    repeat (5) @(negedge clk);
    chk("t3 done", 64'(done), 64'd1);
    check_writes(base, "t3");

    // 4: length above capacity on the 16-word instance, and exactly at capacity
    pulse_reset();
    base4 = we4_cnt;
    fb = {8'hA5, 8'h00, 8'h11};
    send_frame();
    repeat (3) @(negedge clk);
    chk("t4 oversize ERR", 64'({state4, error4, done4, cpu_reset4}), 64'({3'd6, 1'b1, 1'b0, 1'b1}));
    chk("t4 no writes", 64'(we4_cnt - base4), 64'd0);
    pulse_reset();
    fb = {8'hA5, 8'h00, 8'h10};
    send_frame();
    chk("t4 full capacity accepted", 64'(state4), 64'd3);
    pulse_reset();

    // 5: idle timeout mid-frame, then an empty frame
    base = wq.size();
    fb = {8'hA5, 8'h00, 8'h01, 8'hDE, 8'hAD};
    send_frame();
    repeat (150) @(negedge clk);
    chk("t5 still busy before timeout", 64'({busy, error}), 64'({1'b1, 1'b0}));
    repeat (100) @(negedge clk);
    chk("t5 timeout ERR", 64'({state, error, cpu_reset}), 64'({3'd6, 1'b1, 1'b1}));
    chk("t5 no writes", 64'(wq.size() - base), 64'd0);
    fb = {8'hA5, 8'h00, 8'h00, 8'h00};
    send_frame();
    repeat (5) @(negedge clk);
    chk("t5 empty frame", 64'({done, error, words_loaded}), 64'({1'b1, 1'b0, 16'd0}));

    // 6: reset during word 1, then a full frame from address 0
    fb = {8'hA5, 8'h00, 8'h02, 8'h20, 8'h08, 8'h00, 8'h05, 8'h00, 8'h00};
    send_frame();
    chk("t6 mid DATA", 64'({state, words_loaded}), 64'({3'd3, 16'd1}));
    reset = 1'b1;
    repeat (2) @(negedge clk);
    chk_reset("t6 reset mid-frame");
    reset = 1'b0;
    base = wq.size();
    repeat (20) @(negedge clk);
    ew = {32'h20080005, 32'h0000000C};
    build_frame(2, 1'b0);
    send_frame();
    repeat (5) @(negedge clk);
    chk("t6 reload done", 64'({done, words_loaded}), 64'({1'b1, 16'd2}));
    check_writes(base, "t6");
    // low stop bit inside a frame
    fb = {8'hA5, 8'h00, 8'h01};
    send_frame();
    send_byte(8'h12, 1'b0);
    repeat (3) @(negedge clk);
    chk("t6 framing ERR", 64'({state, error, done}), 64'({3'd6, 1'b1, 1'b0}));

    // table-driven frames
    foreach (tbl[t]) begin
      ew = {};
      for (int j = 0; j < tbl[t].n; j++) ew.push_back(tbl[t].w[j]);
      build_frame(tbl[t].n, tbl[t].bad);
      base = wq.size();
      send_frame();
      repeat (5) @(negedge clk);
      chk("table result", 64'({done, error, words_loaded}),
          64'({tbl[t].exp_done, tbl[t].exp_err, tbl[t].exp_wl}));
      check_writes(base, "table");
    end

    // random frames with random inter-frame garbage
    for (int r = 0; r < 8; r++) begin
      ng = $urandom_range(0, 2);
      for (int k = 0; k < ng; k++) begin
        g = 8'($urandom);
        if (g == 8'hA5) g = 8'h5A;
        send_byte(g, 1'b1);
      end
      n   = $urandom_range(1, 5);
      bad = ($urandom_range(0, 2) == 0);
      ew  = {};
      for (int j = 0; j < n; j++) ew.push_back($urandom);
      build_frame(n, bad);
      base = wq.size();
      send_frame();
      repeat (5) @(negedge clk);
      chk("random result", 64'({done, error, cpu_reset, words_loaded}),
          64'({!bad, bad, bad, 16'(n)}));
      check_writes(base, "random");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
